// File: rtl/status_pkg.sv
// Shared status-flag types for the save/restore stack.
// Field order matches the status register's {Z,C,N,O} concatenation.
package status_pkg;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic o;
  } flags_t;

  localparam flags_t FLAGS_RST = 4'b0;

endpackage

// File: rtl/flag_lifo_mem.sv
// DEPTH x 4 register array for saved flag contexts.
// One write port and one combinational read port.
module flag_lifo_mem
  import status_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  flags_t        wdata,
  input  logic [AW-1:0] raddr,
  output flags_t        rdata
);

  flags_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/status_flag_stack.sv
// LIFO save/restore of the {Z,C,N,O} status flags with a registered restore word.
// Define STATUS_FLAG_STACK_ERR_EN to build the sticky ovf_err/udf_err registers.
module status_flag_stack
  import status_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             syn_n_rst,
  input  logic             Z_in,
  input  logic             C_in,
  input  logic             N_in,
  input  logic             O_in,
  input  logic             push,
  input  logic             pop,
  output logic             Z_out,
  output logic             C_out,
  output logic             N_out,
  output logic             O_out,
  output logic             rst_valid,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             udf_err
);

  localparam int AW = $clog2(DEPTH);

  flags_t           cur_flags;
  flags_t           out_q;
  flags_t           top_flags;
  logic [LVL_W-1:0] level_m1;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    waddr;
  logic             do_push, do_pop, do_swap, do_pass, we;

  assign cur_flags = {Z_in, C_in, N_in, O_in};
  assign full      = (level == LVL_W'(DEPTH));
  assign empty     = (level == '0);
  assign level_m1  = level - LVL_W'(1);
  assign top_addr  = level_m1[AW-1:0];

  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign do_swap = push & pop & ~empty;
  assign do_pass = push & pop & empty;

  // A swap rewrites the current top in place; a plain push writes above it.
  assign we    = syn_n_rst & (do_push | do_swap);
  assign waddr = do_push ? level[AW-1:0] : top_addr;

  flag_lifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (cur_flags),
    .raddr (top_addr),
    .rdata (top_flags)
  );

  always_ff @(posedge clk) begin
    if (!syn_n_rst) begin
      level     <= '0;
      out_q     <= FLAGS_RST;
      rst_valid <= 1'b0;
    end else begin
      rst_valid <= do_pop | do_swap | do_pass;
      if (do_pop | do_swap)  out_q <= top_flags;
      else if (do_pass)      out_q <= cur_flags;
      if (do_push)           level <= level + LVL_W'(1);
      else if (do_pop)       level <= level_m1;
    end
  end

  assign Z_out = out_q.z;
  assign C_out = out_q.c;
  assign N_out = out_q.n;
  assign O_out = out_q.o;

`ifdef STATUS_FLAG_STACK_ERR_EN
  always_ff @(posedge clk) begin
    if (!syn_n_rst) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (push & ~pop & full)  ovf_err <= 1'b1;
      if (pop & ~push & empty) udf_err <= 1'b1;
    end
  end
`else
  assign ovf_err = 1'b0;
  assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_status_flag_stack.sv
// Scoreboard bench for status_flag_stack: queue-based stack model, directed then random stimulus.
module tb_status_flag_stack;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             syn_n_rst;
  logic             Z_in, C_in, N_in, O_in;
  logic             push, pop;
  logic             Z_out, C_out, N_out, O_out;
  logic             rst_valid;
  logic [LVL_W-1:0] level;
  logic             full, empty, ovf_err, udf_err;

  status_flag_stack #(.DEPTH(DEPTH)) dut (
    .clk(clk), .syn_n_rst(syn_n_rst),
    .Z_in(Z_in), .C_in(C_in), .N_in(N_in), .O_in(O_in),
    .push(push), .pop(pop),
    .Z_out(Z_out), .C_out(C_out), .N_out(N_out), .O_out(O_out),
    .rst_valid(rst_valid), .level(level), .full(full), .empty(empty),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [3:0] out;
    int         lvl;
    logic       ovf;
    logic       udf;
  } state_t;

  int         vectors = 0;
  int         miscompares = 0;
  state_t     sq[$];
  logic [3:0] rq[$];

  logic [3:0] stk[$];
  logic [3:0] m_out = '0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Stack behaviour straight from the save/restore rules.
  task automatic model(input logic rst_n, input logic ps, input logic pp, input logic [3:0] f);
    state_t s;
    logic   v = 1'b0;
    if (!rst_n) begin
      stk.delete();
      m_out = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (ps && pp) begin
      if (stk.size() == 0) m_out = f;
      else begin
        m_out = stk.pop_back();
        stk.push_back(f);
      end
      v = 1'b1;
    end else if (ps) begin
      if (stk.size() == DEPTH) m_ovf = 1'b1;
      else stk.push_back(f);
    end else if (pp) begin
      if (stk.size() == 0) m_udf = 1'b1;
      else begin
        m_out = stk.pop_back();
        v = 1'b1;
      end
    end
    if (v) rq.push_back(m_out);
    s.valid = v;
    s.out   = m_out;
    s.lvl   = stk.size();
`ifdef STATUS_FLAG_STACK_ERR_EN
    s.ovf = m_ovf;
    s.udf = m_udf;
`else
    s.ovf = 1'b0;
    s.udf = 1'b0;
`endif
    sq.push_back(s);
  endtask

  task automatic cycle(input logic rst_n, input logic ps, input logic pp, input logic [3:0] f);
    @(negedge clk);
    syn_n_rst = rst_n;
    push = ps;
    pop = pp;
    {Z_in, C_in, N_in, O_in} = f;
    model(rst_n, ps, pp, f);
  endtask

  always @(posedge clk) begin
    state_t     s;
    logic [3:0] e;
    #1;
    if (sq.size() > 0) begin
      s = sq.pop_front();
      chk("rst_valid", {7'b0, rst_valid}, {7'b0, s.valid});
      chk("level", 8'(level), 8'(s.lvl));
      chk("full", {7'b0, full}, {7'b0, s.lvl == DEPTH});
      chk("empty", {7'b0, empty}, {7'b0, s.lvl == 0});
      chk("ovf_err", {7'b0, ovf_err}, {7'b0, s.ovf});
      chk("udf_err", {7'b0, udf_err}, {7'b0, s.udf});
      chk("flags_out", {4'b0, Z_out, C_out, N_out, O_out}, {4'b0, s.out});
    end
    if (rst_valid === 1'b1) begin
      if (rq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL restore at %0t: got unexpected rst_valid expected none", $time);
      end else begin
        e = rq.pop_front();
        chk("restore", {4'b0, Z_out, C_out, N_out, O_out}, {4'b0, e});
      end
    end
  end

  initial begin
    syn_n_rst = 1'b0; push = 1'b0; pop = 1'b0;
    {Z_in, C_in, N_in, O_in} = 4'b0;

    cycle(1'b0, 1'b1, 1'b1, 4'hF);
    cycle(1'b0, 1'b1, 1'b1, 4'hA);
    // LIFO order
    cycle(1'b1, 1'b1, 1'b0, 4'b1000);
    cycle(1'b1, 1'b1, 1'b0, 4'b0100);
    cycle(1'b1, 1'b1, 1'b0, 4'b0011);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 4'h0);
    // fill, overflow, drain
    for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b1, 1'b0, 4'(i));
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 4'h0);
    // underflow
    cycle(1'b1, 1'b0, 1'b1, 4'h7);
    cycle(1'b1, 1'b0, 1'b0, 4'h0);
    // swap at level 2, then pass-through on empty
    cycle(1'b1, 1'b1, 1'b0, 4'b0011);
    cycle(1'b1, 1'b1, 1'b0, 4'b0101);
    cycle(1'b1, 1'b1, 1'b1, 4'b1010);
    cycle(1'b1, 1'b0, 1'b1, 4'h0);
    cycle(1'b1, 1'b0, 1'b1, 4'h0);
    cycle(1'b1, 1'b1, 1'b1, 4'b1110);
    // reset mid-operation
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 4'(9 + i));
    cycle(1'b0, 1'b0, 1'b1, 4'h0);
    cycle(1'b1, 1'b0, 1'b1, 4'h0);

    for (int i = 0; i < 3000; i++) begin
      logic rn, ps, pp;
      rn = ($urandom_range(0, 63) != 0);
      ps = ($urandom_range(0, 99) < 45);
      pp = ($urandom_range(0, 99) < 40);
      cycle(rn, ps, pp, 4'($urandom));
    end

    cycle(1'b1, 1'b0, 1'b0, 4'h0);
    repeat (3) @(negedge clk);
    chk("restore_queue_drained", 8'(rq.size()), 8'd0);
    chk("state_queue_drained", 8'(sq.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/status_flag_stack.md
# status_flag_stack

Save/restore stack for the processor status flags {Z,C,N,O}. It reads the outputs of the status register and pushes them on exception/interrupt entry. On return it pops them back out as a registered restore word, which the flag-source mux feeds into the status register's inputs. It sits beside the status register in the datapath and is driven by the control unit's push/pop strobes.

## Interface
Parameters:
- DEPTH, 4, number of saved flag contexts (power of two, ≥2)
- LVL_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
- clk  in  1  single system clock, rising edge
- syn_n_rst  in  1  reset, synchronous, active-low
- Z_in, C_in, N_in, O_in  in  1 each  current flags from the status register
- push  in  1  save current flags (one-cycle strobe)
- pop  in  1  restore most recent context (one-cycle strobe)
- Z_out, C_out, N_out, O_out  out  1 each  restored flags, registered
- rst_valid  out  1  one-cycle pulse: restore word on *_out is valid
- level  out  LVL_W  contexts currently held
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- ovf_err, udf_err  out  1 each  sticky error flags (see Configuration)

## Operation
- Storage: DEPTH entries of 4 bits, LIFO, write pointer = level.
- push only, not full: mem[level] <= {Z_in,C_in,N_in,O_in}; level+1.
- pop only, not empty: {Z_out..O_out} <= mem[level-1]; rst_valid <= 1; level-1.
- push and pop together, not empty: swap.
  - Outputs get the old top; the top is overwritten with the current flags; level is unchanged; rst_valid = 1.
- push and pop together, empty: the flags pass straight through, so *_out <= current flags and rst_valid = 1. Level stays 0 and no error is raised.
- push while full (without pop): ignored; memory and level unchanged; sets ovf_err.
- pop while empty (without push): ignored; rst_valid stays 0; *_out hold their value; sets udf_err.
- *_out hold their last restored value until the next valid pop.
- full and empty are combinational decodes of the level register.
- Reset (syn_n_rst low at a rising edge):
  - level = 0, *_out = 0, rst_valid = 0, ovf_err = udf_err = 0.
  - Memory contents are don't-care.
  - Reset overrides any push/pop sampled in the same cycle, including mid-sequence.

## Timing
- All state updates happen on the rising edge of clk.
- Pop latency is 1 cycle: pop sampled at edge N gives *_out and rst_valid valid after edge N, for cycle N+1 only.
- Back-to-back pops on consecutive cycles restore consecutive entries, one per cycle, with rst_valid high on each.
- Push-to-pop turnaround: a value pushed at edge N can be popped at edge N+1.
- Push samples *_in at the same edge as the strobe, so no flag update from that edge is captured.
- level, full and empty reflect the post-edge state.

## Configuration
- Macro STATUS_FLAG_STACK_ERR_EN.
- Defined:
  - ovf_err and udf_err are sticky registers.
  - They set on the illegal operation and clear only on reset.
- Not defined:
  - ovf_err and udf_err are tied to 0; no error registers are built.
  - Illegal push/pop are still ignored exactly as above.

## Structure
- Shared package status_pkg holds:
  - typedef flags_t, a packed struct {Z,C,N,O}, 4 bits, with Z as the MSB to match the status register's {Z,C,N,O} concatenation.
  - Constant FLAGS_RST = 4'b0.
- One sub-module, flag_lifo_mem: the DEPTH×4 register array with write port (we, waddr, wdata) and read port (raddr, combinational rdata).
- Level/pointer control, swap logic, output registers and error flags live in the top module.

## Test plan
- Reset: hold syn_n_rst low 2 cycles with push=pop=1 -> level=0, empty=1, rst_valid=0, *_out=0, errors=0.
- LIFO order: push 4'b1000, 4'b0100, 4'b0011 on three cycles, then pop three times -> outputs 0011, 0100, 1000 on consecutive cycles, rst_valid high each, empty=1 at end.
- Full and overflow (DEPTH=4): push 5 times -> full=1 after the 4th, level=4, ovf_err=1 after the 5th; four pops then return the first four values only.
- Underflow: pop when empty -> rst_valid=0, *_out unchanged, udf_err=1 (0 with macro undefined).
- Simultaneous push/pop: at level=2 with top=0101 and flags_in=1010 -> *_out=0101, level=2; next pop returns 1010.
- Reset mid-operation: at level=3, assert reset with pop=1 -> no rst_valid pulse, level=0; next pop flags underflow.
